// File: rtl/if_inst_queue_pkg.sv
// -----------------------------------------------------------------------------
// if_inst_queue_pkg
//   Shared constants and types for the instruction fetch queue.
//   Mirrors the fetch-side defines (address/instruction bus widths, the zero
//   word that decodes as a NOP, reset/chip-enable levels) and the default
//   queue depth.
// -----------------------------------------------------------------------------
package if_inst_queue_pkg;

   localparam int          INST_ADDR_W = 32;     // InstAddrBus
   localparam int          INST_W      = 32;     // InstBus
   localparam logic [31:0] ZERO_WORD   = 32'h0;  // decodes as NOP
   localparam logic        RST_ENABLE  = 1'b1;
   localparam logic        RST_DISABLE = 1'b0;
   localparam logic        CHIP_ENABLE = 1'b1;
   localparam logic        CHIP_DISABLE = 1'b0;
   localparam int          IFQ_DEPTH   = 4;

   // One queued fetch: PC in the upper half, instruction word in the lower.
   typedef struct packed {
      logic [INST_ADDR_W-1:0] pc;
      logic [INST_W-1:0]      inst;
   } ifq_entry_t;

endpackage

// File: rtl/if_inst_queue_mem.sv
// -----------------------------------------------------------------------------
// if_inst_queue_mem
//   DEPTH x 64-bit storage for the fetch queue. Synchronous write port,
//   combinational read port, no reset (contents are only ever read at
//   positions the control logic has already written).
// Ports:
//   clk      - system clock, rising edge
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - entry to store
//   raddr_i  - read address
//   rdata_o  - entry at raddr_i (combinational)
// -----------------------------------------------------------------------------
module if_inst_queue_mem
   import if_inst_queue_pkg::*;
#(
   parameter int DEPTH = IFQ_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [PTR_W-1:0] waddr_i,
   input  ifq_entry_t       wdata_i,
   input  logic [PTR_W-1:0] raddr_i,
   output ifq_entry_t       rdata_o
);

   ifq_entry_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_inst_queue.sv
// -----------------------------------------------------------------------------
// if_inst_queue
//   Instruction fetch queue between pc_reg/inst_rom and the IF/ID register.
//   Captures {pc, inst} pairs into a small FIFO, presents the oldest to decode
//   with a valid/ready handshake and back-pressures fetch when full. Flush
//   empties the queue in one cycle.
//
//   Handshake: a transfer happens on a rising edge when valid and ready are
//   both high. in_ready depends only on occupancy (never on out_ready), so a
//   full queue that pops this cycle accepts again on the next one. Neither
//   output valid nor output data depend combinationally on any input.
//
// Ports:
//   clk, rst             - clock; asynchronous active-high reset
//   in_valid/in_ready    - fetch side handshake
//   in_pc, in_inst       - fetched PC and instruction word
//   out_valid/out_ready  - decode side handshake
//   out_pc, out_inst     - head entry (zero when empty)
//   flush                - discard all entries (redirect)
//   count                - occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module if_inst_queue
   import if_inst_queue_pkg::*;
#(
   parameter int DEPTH = IFQ_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [INST_ADDR_W-1:0] in_pc,
   input  logic [INST_W-1:0]      in_inst,
   output logic                   in_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INST_ADDR_W-1:0] out_pc,
   output logic [INST_W-1:0]      out_inst,
   input  logic                   flush,
   output logic [PTR_W:0]         count
);

   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q,  count_d;
   logic             push, pop;
   ifq_entry_t       wr_entry, head_entry;

   assign in_ready  = (count_q != FULL_CNT);
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign count     = count_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         // Redirect: drop everything, including this cycle's push/pop.
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign wr_entry.pc   = in_pc;
   assign wr_entry.inst = in_inst;

   if_inst_queue_mem #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_mem (
      .clk     (clk),
      .we_i    (push & ~flush),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_entry),
      .raddr_i (rd_ptr_q),
      .rdata_o (head_entry)
   );

   // Empty queue presents ZERO_WORD so decode sees a NOP, not stale storage.
   assign out_pc   = out_valid ? head_entry.pc   : ZERO_WORD;
   assign out_inst = out_valid ? head_entry.inst : ZERO_WORD;

`ifndef SYNTHESIS
   a_no_push_full : assert property (@(posedge clk) disable iff (rst)
      !(push && (count_q == FULL_CNT)));
   a_no_pop_empty : assert property (@(posedge clk) disable iff (rst)
      !(pop && (count_q == '0)));
   a_ptr_count    : assert property (@(posedge clk) disable iff (rst)
      ((count_q == '0) || (count_q == FULL_CNT)) ||
      (count_q[PTR_W-1:0] == PTR_W'(wr_ptr_q - rd_ptr_q)));
`endif

endmodule

// File: tb/tb_if_inst_queue.sv
// -----------------------------------------------------------------------------
// tb_if_inst_queue
//   Directed bench for the instruction fetch queue. A reference queue of
//   {pc, inst} entries tracks what decode should see after every edge; the
//   directed phases add hand-computed checks at the interesting points.
// -----------------------------------------------------------------------------
module tb_if_inst_queue;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic [31:0]       in_pc;
   logic [31:0]       in_inst;
   logic              in_ready;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_pc;
   logic [31:0]       out_inst;
   logic              flush;
   logic [PTR_W:0]    count;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   logic [63:0] exp_q[$];

   if_inst_queue #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_pc     (in_pc),
      .in_inst   (in_inst),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_inst  (out_inst),
      .flush     (flush),
      .count     (count)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Compare every output against the reference queue.
   task automatic check_model(input string tag);
      logic [63:0] head;
      head = (exp_q.size() != 0) ? exp_q[0] : 64'h0;
      check({tag, ".count"},     64'(count),     64'(exp_q.size()));
      check({tag, ".out_valid"}, 64'(out_valid), 64'(exp_q.size() != 0));
      check({tag, ".in_ready"},  64'(in_ready),  64'(exp_q.size() != DEPTH));
      check({tag, ".out_pc"},    64'(out_pc),    64'(head[63:32]));
      check({tag, ".out_inst"},  64'(out_inst),  64'(head[31:0]));
   endtask

   // Apply the current inputs for one edge: update the reference with what
   // this edge should do, then sample 1 time unit after the edge.
   task automatic step(input string tag);
      logic do_pop, do_push;
      if (flush) begin
         exp_q.delete();
      end else begin
         do_pop  = (exp_q.size() != 0) && out_ready;
         do_push = in_valid && (exp_q.size() != DEPTH);
         if (do_pop)  void'(exp_q.pop_front());
         if (do_push) exp_q.push_back({in_pc, in_inst});
      end
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic r, input logic f);
      in_valid  = v;
      in_pc     = pc;
      in_inst   = 32'hA500_0000 | pc;
      out_ready = r;
      flush     = f;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      #2;
      check("rst.count",     64'(count),     64'd0);
      check("rst.out_valid", 64'(out_valid), 64'd0);
      check("rst.out_pc",    64'(out_pc),    64'd0);
      check("rst.out_inst",  64'(out_inst),  64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("rst.in_ready",  64'(in_ready),  64'd1);

      // Fill with out_ready low.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
         step("fill");
         check("fill.head_pc", 64'(out_pc), 64'h0);
      end
      check("full.count",    64'(count),    64'd4);
      check("full.in_ready", 64'(in_ready), 64'd0);
      drive(1'b1, 32'h10, 1'b0, 1'b0);
      step("fifth_push");
      check("fifth.count",   64'(count),  64'd4);
      check("fifth.out_pc",  64'(out_pc), 64'h0);

      // Drain in order.
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         check("drain.out_pc", 64'(out_pc), 64'(i * 4));
         step("drain");
      end
      check("drain.out_valid", 64'(out_valid), 64'd0);
      check("drain.out_inst",  64'(out_inst),  64'd0);
      check("drain.count",     64'(count),     64'd0);

      // Streaming across several wraps: head trails input by one edge.
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < 3 * DEPTH + 2; i++) begin
         drive(1'b1, 32'(i * 4), (i != 0), 1'b0);
         step("stream");
         check("stream.count",  64'(count),  64'd1);
         check("stream.out_pc", 64'(out_pc), 64'(i * 4));
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      step("stream_tail");

      // Full with simultaneous pop: push rejected, accepted next cycle.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 32'h40 + 32'(i * 4), 1'b0, 1'b0);
         step("refill");
      end
      drive(1'b1, 32'h200, 1'b1, 1'b0);
      step("full_pop");
      check("full_pop.count",    64'(count),    64'd3);
      check("full_pop.in_ready", 64'(in_ready), 64'd1);
      check("full_pop.out_pc",   64'(out_pc),   64'h44);
      drive(1'b1, 32'h200, 1'b0, 1'b0);
      step("represent");
      check("represent.count", 64'(count), 64'd4);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH; i++) step("drain2");
      check("drain2.count", 64'(count), 64'd0);

      // Flush with simultaneous push and pop.
      drive(1'b1, 32'h80, 1'b0, 1'b0);
      step("pre_flush0");
      drive(1'b1, 32'h84, 1'b0, 1'b0);
      step("pre_flush1");
      check("pre_flush.count", 64'(count), 64'd2);
      drive(1'b1, 32'h300, 1'b1, 1'b1);
      step("flush");
      check("flush.count",     64'(count),     64'd0);
      check("flush.out_valid", 64'(out_valid), 64'd0);
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h304, 1'b0, 1'b1);
         step("flush_hold");
         check("flush_hold.in_ready", 64'(in_ready), 64'd1);
      end
      drive(1'b1, 32'h100, 1'b0, 1'b0);
      step("post_flush");
      check("post_flush.out_pc",   64'(out_pc),   64'h100);
      check("post_flush.out_inst", 64'(out_inst), 64'hA500_0100);
      check("post_flush.count",    64'(count),    64'd1);

      // Async reset between edges with three entries queued.
      drive(1'b1, 32'h104, 1'b0, 1'b0);
      step("pre_rst0");
      drive(1'b1, 32'h108, 1'b0, 1'b0);
      step("pre_rst1");
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check("pre_rst.count", 64'(count), 64'd3);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst.count",     64'(count),     64'd0);
      check("async_rst.out_valid", 64'(out_valid), 64'd0);
      check("async_rst.out_pc",    64'(out_pc),    64'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 32'h500, 1'b0, 1'b0);
      step("after_rst");

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/if_inst_queue.md
Name: if_inst_queue

Overview:
- Instruction fetch queue between the PC register / instruction ROM pair and the IF/ID pipeline register.
- Captures {pc, inst} pairs from the fetch stage into a small FIFO.
- Presents the oldest entry to decode with a valid/ready handshake, and back-pressures fetch when full.
- Flush (branch/exception redirect) discards every queued entry in one cycle.

Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..16.
- PTR_W, 2, pointer width, clog2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high (`RstEnable` = 1'b1).
- in_valid  input  1  fetch entry present; driven from pc_reg ce (`ChipEnable`).
- in_pc  input  32 (`InstAddrBus`)  PC of the fetched instruction.
- in_inst  input  32 (`InstBus`)  instruction word read from the ROM.
- in_ready  output  1  queue can accept this cycle; fetch stalls its PC when low.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  32  head PC.
- out_inst  output  32  head instruction.
- flush  input  1  discard all entries; redirect pending.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (async, rst=1):
  - rd_ptr = wr_ptr = 0, count = 0.
  - out_valid = 0, out_pc = 0, out_inst = 0 (`ZeroWord`, decodes as NOP).
  - in_ready = 1 once rst deasserts. Storage array is not cleared.
- Push: in_valid & in_ready at a rising edge writes {in_pc, in_inst} at wr_ptr; wr_ptr advances and wraps modulo DEPTH.
- Pop: out_valid & out_ready at a rising edge advances rd_ptr, which wraps modulo DEPTH.
- in_ready = (count != DEPTH). It is combinational from count only, never from out_ready. A full queue never accepts in the same cycle it pops; it accepts on the cycle after.
- out_valid = (count != 0). out_pc and out_inst read the head combinationally; both are forced to 0 when count = 0.
- Latency: an entry pushed into an empty queue is visible on out_valid on the next cycle. There is no same-cycle bypass.
- Occupancy update per edge, with push and pop as defined above:
  - push only: count + 1.
  - pop only: count − 1.
  - push and pop together: count unchanged; both pointers advance.
  - neither: count unchanged.
- Flush has highest priority after reset. On an edge with flush = 1:
  - rd_ptr = wr_ptr = 0, count = 0.
  - Any simultaneous push or pop is discarded.
  - out_valid = 0 on the following cycle.
- Flush held for several cycles keeps the queue empty, and in_ready stays 1.
- Reset asserted mid-operation clears state immediately, with no wait for a clock edge.
- Arithmetic:
  - count is PTR_W+1 bits, so DEPTH is representable.
  - Pointers are PTR_W bits and wrap naturally.
  - Overflow and underflow cannot occur by construction.
- Assertions (simulation only):
  - No push when count = DEPTH.
  - No pop when count = 0.
  - count equals (wr_ptr − rd_ptr) mod DEPTH, except when count is 0 or DEPTH.

Decomposition:
- Shared define file (existing define.v) holds `InstAddrBus`, `InstBus`, `ZeroWord`, `RstEnable`/`RstDisable`, `ChipEnable`/`ChipDisable`. Add `IfqDepth` (4) there for the default depth.
- One natural sub-module: ifq_mem, a DEPTH×64 register array with a synchronous write port and a combinational read port. It has no reset.
- Control (pointers, count, flush) stays in if_inst_queue.

Test Plan:
- Reset, then fill: hold out_ready=0 and push pc 0x0,0x4,0x8,0xC with distinct insts.
  - Expect count=4 and in_ready=0 after the 4th edge.
  - A 5th push is ignored; out_pc=0x0 throughout.
- Drain in order: from full, assert out_ready for 4 cycles.
  - Expect out_pc sequence 0x0,0x4,0x8,0xC, then out_valid=0, out_inst=0, count=0.
- Streaming: continuous in_valid with pc 0x0,+4…, out_ready=1 from cycle 1.
  - Expect count to settle at 1.
  - Expect out_pc to trail in_pc by one cycle, with wrap across ≥3×DEPTH entries and no loss.
- Full with simultaneous pop: count=4, in_valid=1, out_ready=1.
  - Expect count=3 next edge and the push rejected that cycle.
  - On the next cycle in_ready=1; the re-presented entry is accepted and count returns to 4.
- Flush with push and pop: count=2, flush=1, in_valid=1, out_ready=1 on the same edge.
  - Expect count=0 and out_valid=0 next cycle, and the pushed entry never appears.
  - A subsequent push of pc 0x100 is the first entry out.
- Async reset mid-stream: assert rst between clock edges with count=3.
  - Expect count=0, out_valid=0, out_pc=0 immediately, before the next edge.
